// File: rtl/n_risc.sv
`default_nettype none
// ============================================================================
// Module      : n_risc
// Description : Single-cycle 8-bit Harvard load/store core. One instruction
//               per clock, 4x8-bit register file, separate instruction and
//               data ports to external combinational-read memories.
// Revision    : 1.0 - initial release
// ============================================================================
module n_risc (
   input  logic       Clock,
   input  logic       Reset,
   output logic [7:0] EnderecoInstrucao,
   input  logic [7:0] InstrucaoLida,
   output logic [7:0] EnderecoDados,
   output logic [7:0] DadoEscrito,
   input  logic [7:0] DadoLido,
   output logic       MemWrite,
   output logic       MemRead
);

   localparam logic [2:0] C_OP_ADDSUB = 3'b000;
   localparam logic [2:0] C_OP_ANDOR  = 3'b001;
   localparam logic [2:0] C_OP_ADDI   = 3'b010;
   localparam logic [2:0] C_OP_LW     = 3'b011;
   localparam logic [2:0] C_OP_SW     = 3'b100;
   localparam logic [2:0] C_OP_BEQZ   = 3'b101;
   localparam logic [2:0] C_OP_J      = 3'b110;
   localparam logic [2:0] C_OP_SLTMOV = 3'b111;

   logic [7:0] r_pc;
   logic [7:0] r_regs [0:3];

   logic [2:0] w_op;
   logic [1:0] w_rd;
   logic [1:0] w_rs;
   logic       w_f;
   logic [7:0] w_imm3Ext;
   logic [7:0] w_rdVal;
   logic [7:0] w_rsVal;
   logic [7:0] w_pcPlus1;
   logic [7:0] w_nextPc;
   logic [7:0] w_wrData;
   logic       w_regWe;
   logic       w_memRead;
   logic       w_memWrite;

   // Field decode and combinational register-file reads
   assign w_op      = InstrucaoLida[7:5];
   assign w_rd      = InstrucaoLida[4:3];
   assign w_rs      = InstrucaoLida[2:1];
   assign w_f       = InstrucaoLida[0];
   assign w_imm3Ext = {{5{InstrucaoLida[2]}}, InstrucaoLida[2:0]};
   assign w_rdVal   = r_regs[w_rd];
   assign w_rsVal   = r_regs[w_rs];
   assign w_pcPlus1 = r_pc + 8'd1;

   // Execute: next PC, write-back value and memory strobes for this instruction
   always_comb begin
      w_nextPc   = w_pcPlus1;
      w_wrData   = w_rdVal;
      w_regWe    = 1'b0;
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
      case (w_op)
         C_OP_ADDSUB: begin
            w_regWe  = 1'b1;
            w_wrData = w_f ? (w_rdVal - w_rsVal) : (w_rdVal + w_rsVal);
         end
         C_OP_ANDOR: begin
            w_regWe  = 1'b1;
            w_wrData = w_f ? (w_rdVal | w_rsVal) : (w_rdVal & w_rsVal);
         end
         C_OP_ADDI: begin
            w_regWe  = 1'b1;
            w_wrData = w_rdVal + w_imm3Ext;
         end
         C_OP_LW: begin
            w_regWe   = 1'b1;
            w_memRead = 1'b1;
            w_wrData  = DadoLido;
         end
         C_OP_SW: begin
            w_memWrite = 1'b1;
         end
         C_OP_BEQZ: begin
            if (w_rdVal == 8'd0) begin
               w_nextPc = w_pcPlus1 + w_imm3Ext;
            end
         end
         C_OP_J: begin
            w_nextPc = {3'b000, InstrucaoLida[4:0]};
         end
         C_OP_SLTMOV: begin
            w_regWe = 1'b1;
            if (w_f) begin
               w_wrData = w_rsVal;
            end else begin
               w_wrData = ($signed(w_rdVal) < $signed(w_rsVal)) ? 8'd1 : 8'd0;
            end
         end
         default: begin
            w_nextPc = w_pcPlus1;
         end
      endcase
   end

   // Memory ports; strobes are held low while reset is asserted
   assign EnderecoInstrucao = r_pc;
   assign EnderecoDados     = w_rsVal;
   assign DadoEscrito       = w_rdVal;
   assign MemRead           = w_memRead  & ~Reset;
   assign MemWrite          = w_memWrite & ~Reset;

   // Architectural state: PC and destination register commit together
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_pc <= 8'd0;
         for (int i = 0; i < 4; i++) begin
            r_regs[i] <= 8'd0;
         end
      end else begin
         r_pc <= w_nextPc;
         if (w_regWe) begin
            r_regs[w_rd] <= w_wrData;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_n_risc.sv
`default_nettype none
// ============================================================================
// Module      : tb_n_risc
// Description : Self-checking bench for n_risc. Table-driven instruction
//               vectors plus hand-written reset, branch and wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n_risc;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [7:0] EnderecoInstrucao;
   logic [7:0] InstrucaoLida;
   logic [7:0] EnderecoDados;
   logic [7:0] DadoEscrito;
   logic [7:0] DadoLido;
   logic       MemWrite;
   logic       MemRead;

   logic       tbDrive;
   logic [7:0] drvInstr;
   logic       dmemInit;
   logic [7:0] imem [0:255];
   logic [7:0] dmem [0:255];

   int checks = 0;
   int errors = 0;

   n_risc dut (
      .Clock             (Clock),
      .Reset             (Reset),
      .EnderecoInstrucao (EnderecoInstrucao),
      .InstrucaoLida     (InstrucaoLida),
      .EnderecoDados     (EnderecoDados),
      .DadoEscrito       (DadoEscrito),
      .DadoLido          (DadoLido),
      .MemWrite          (MemWrite),
      .MemRead           (MemRead)
   );

   always #5 Clock = ~Clock;

   // Instruction source: bench-driven word or preloaded instruction memory
   assign InstrucaoLida = tbDrive ? drvInstr : imem[EnderecoInstrucao];
   assign DadoLido      = dmem[EnderecoDados];

   // Data memory model: synchronous write, combinational read
   always @(posedge Clock) begin
      if (dmemInit) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 8'hA5;
      end else if (MemWrite) begin
         dmem[EnderecoDados] <= DadoEscrito;
      end
   end

   typedef struct {
      string      name;
      logic [7:0] instr;
      logic       expRead;
      logic       expWrite;
      logic [1:0] chkReg;
      logic [7:0] expVal;
      logic [7:0] expPc;
   } vec_t;

   vec_t vecs [0:14];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Read a register by presenting SW rX,(r0) and sampling DadoEscrito
   task automatic peek(input logic [1:0] idx, output logic [7:0] val);
      logic       saveDrive;
      logic [7:0] saveInstr;
      saveDrive = tbDrive;
      saveInstr = drvInstr;
      tbDrive   = 1'b1;
      drvInstr  = {3'b100, idx, 3'b000};
      #1;
      val       = DadoEscrito;
      tbDrive   = saveDrive;
      drvInstr  = saveInstr;
      #1;
   endtask

   task automatic checkReg(input string name, input logic [1:0] idx, input logic [7:0] exp);
      logic [7:0] v;
      peek(idx, v);
      check(name, v, exp);
   endtask

   initial begin
      logic [7:0] v;
      int guard;

      vecs[0]  = '{"addi_r1_p3",  8'h4B, 1'b0, 1'b0, 2'd1, 8'h03, 8'h01};
      vecs[1]  = '{"addi_r2_m1",  8'h57, 1'b0, 1'b0, 2'd2, 8'hFF, 8'h02};
      vecs[2]  = '{"add_r1_r2",   8'h0C, 1'b0, 1'b0, 2'd1, 8'h02, 8'h03};
      vecs[3]  = '{"sub_r1_r2",   8'h0D, 1'b0, 1'b0, 2'd1, 8'h03, 8'h04};
      vecs[4]  = '{"slt_r2_r1",   8'hF2, 1'b0, 1'b0, 2'd2, 8'h01, 8'h05};
      vecs[5]  = '{"and_r2_r1",   8'h32, 1'b0, 1'b0, 2'd2, 8'h01, 8'h06};
      vecs[6]  = '{"or_r2_r1",    8'h33, 1'b0, 1'b0, 2'd2, 8'h03, 8'h07};
      vecs[7]  = '{"addi_r0_m4",  8'h44, 1'b0, 1'b0, 2'd0, 8'hFC, 8'h08};
      vecs[8]  = '{"slt_neg_pos", 8'hE2, 1'b0, 1'b0, 2'd0, 8'h01, 8'h09};
      vecs[9]  = '{"slt_false",   8'hE8, 1'b0, 1'b0, 2'd1, 8'h00, 8'h0A};
      vecs[10] = '{"mov_r3_r2",   8'hFD, 1'b0, 1'b0, 2'd3, 8'h03, 8'h0B};
      vecs[11] = '{"addi_r2_m4",  8'h54, 1'b0, 1'b0, 2'd2, 8'hFF, 8'h0C};
      vecs[12] = '{"addi_r1_p3b", 8'h4B, 1'b0, 1'b0, 2'd1, 8'h03, 8'h0D};
      vecs[13] = '{"sw_r2_r1",    8'h92, 1'b0, 1'b1, 2'd2, 8'hFF, 8'h0E};
      vecs[14] = '{"lw_r0_r1",    8'h62, 1'b1, 1'b0, 2'd0, 8'hFF, 8'h0F};

      for (int i = 0; i < 256; i++) imem[i] = 8'h40;
      imem[0] = 8'h4B;

      Reset    = 1'b1;
      tbDrive  = 1'b1;
      drvInstr = 8'h92;
      dmemInit = 1'b1;
      step();
      step();
      dmemInit = 1'b0;

      // Reset state with an SW presented
      check("rst_pc", EnderecoInstrucao, 8'h00);
      check("rst_memwrite", {7'd0, MemWrite}, 8'h00);
      check("rst_memread", {7'd0, MemRead}, 8'h00);
      for (int r = 0; r < 4; r++) checkReg("rst_reg", 2'(r), 8'h00);

      Reset = 1'b0;
      #1;

      // Table-driven instruction vectors
      for (int i = 0; i < 15; i++) begin
         drvInstr = vecs[i].instr;
         #1;
         check({vecs[i].name, "_memread"}, {7'd0, MemRead}, {7'd0, vecs[i].expRead});
         check({vecs[i].name, "_memwrite"}, {7'd0, MemWrite}, {7'd0, vecs[i].expWrite});
         if (vecs[i].expWrite) begin
            check({vecs[i].name, "_addr"}, EnderecoDados, 8'h03);
            check({vecs[i].name, "_data"}, DadoEscrito, 8'hFF);
         end
         step();
         checkReg({vecs[i].name, "_reg"}, vecs[i].chkReg, vecs[i].expVal);
         check({vecs[i].name, "_pc"}, EnderecoInstrucao, vecs[i].expPc);
      end
      check("dmem3_after_sw", dmem[3], 8'hFF);

      // Reset asserted mid-cycle while SW r2,(r1) is presented
      drvInstr = 8'h92;
      #1;
      check("pre_rst_memwrite", {7'd0, MemWrite}, 8'h01);
      Reset = 1'b1;
      #1;
      check("midrst_pc", EnderecoInstrucao, 8'h00);
      check("midrst_memwrite", {7'd0, MemWrite}, 8'h00);
      check("midrst_memread", {7'd0, MemRead}, 8'h00);
      for (int r = 0; r < 4; r++) checkReg("midrst_reg", 2'(r), 8'h00);
      step();
      check("midrst_no_write", dmem[0], 8'hA5);
      check("midrst_persist", dmem[3], 8'hFF);

      // Restart from address 0 using the instruction memory
      tbDrive = 1'b0;
      Reset   = 1'b0;
      #1;
      check("restart_pc0", EnderecoInstrucao, 8'h00);
      step();
      check("restart_pc1", EnderecoInstrucao, 8'h01);
      checkReg("restart_r1", 2'd1, 8'h03);

      // Branch loop: BEQZ r3,-1 at PC 5
      tbDrive  = 1'b1;
      drvInstr = 8'hC5; step();
      check("j5_pc", EnderecoInstrucao, 8'h05);
      drvInstr = 8'hBF; step();
      check("beqz_taken1", EnderecoInstrucao, 8'h05);
      step();
      check("beqz_taken2", EnderecoInstrucao, 8'h05);
      drvInstr = 8'h59; step();
      checkReg("r3_one", 2'd3, 8'h01);
      drvInstr = 8'hC5; step();
      drvInstr = 8'hBF; step();
      check("beqz_not_taken", EnderecoInstrucao, 8'h06);

      // Jump to top of absolute range
      drvInstr = 8'hDF; step();
      check("j1f_pc", EnderecoInstrucao, 8'h1F);

      // Walk to 0xFE, then taken BEQZ r0,+3 wraps to 0x02
      drvInstr = 8'h40;
      guard = 0;
      while (EnderecoInstrucao != 8'hFE && guard < 300) begin
         step();
         guard++;
      end
      check("reach_fe", EnderecoInstrucao, 8'hFE);
      drvInstr = 8'hA3; step();
      check("beqz_wrap", EnderecoInstrucao, 8'h02);

      // Sequential wrap from 0xFF to 0x00
      drvInstr = 8'hDF; step();
      drvInstr = 8'h40;
      guard = 0;
      while (EnderecoInstrucao != 8'hFF && guard < 300) begin
         step();
         guard++;
      end
      check("reach_ff", EnderecoInstrucao, 8'hFF);
      step();
      check("pc_wrap", EnderecoInstrucao, 8'h00);
      peek(2'd0, v);
      check("r0_untouched", v, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
